// File: rtl/cpu_bus_ctrl_pkg.sv
// Shared types and constants for the CPU external bus controller.
package cpu_bus_pkg;

   // Controller FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MEM  = 2'd1,
      ST_IO   = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   // Address decode result
   typedef enum logic [1:0] {
      T_MEM  = 2'd0,
      T_IO   = 2'd1,
      T_NONE = 2'd2
   } target_e;

   // Value returned for reads that cannot be served
   localparam logic [31:0] BUS_FILL = 32'hFFFF_FFFF;

endpackage

// File: rtl/cpu_bus_ctrl_if.sv
// CPU-side request/response bundle of the bus controller.
interface cpu_bus_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              i_req;
   logic              i_we;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_wdata;
   logic [DATA_W-1:0] o_rdata;
   logic              o_ready;

   // CPU side drives the request, reads the response
   modport master (
      output i_req, i_we, i_addr, i_wdata,
      input  o_rdata, o_ready
   );

   // Controller side
   modport slave (
      input  i_req, i_we, i_addr, i_wdata,
      output o_rdata, o_ready
   );
endinterface

// File: rtl/cpu_bus_ctrl_decode.sv
// Combinational address-to-target decode; the I/O window takes priority
// over the memory range.
module cpu_bus_decode
   import cpu_bus_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] MEM_LIMIT = 32'h0100_0000,
   parameter logic [15:0]       IO_BASE   = 16'hFF00
) (
   input  logic [ADDR_W-1:0] i_addr,
   output target_e           o_target
);

   // Pick the target for the presented address
   always_comb begin
      o_target = T_NONE;
      if (i_addr[ADDR_W-1 -: 16] == IO_BASE) begin
         o_target = T_IO;
      end else if (i_addr < MEM_LIMIT) begin
         o_target = T_MEM;
      end
   end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// CPU external bus controller: accepts one request per rising strobe,
// routes it to memory, the I/O window or nowhere, and returns a one-cycle
// ready pulse with read data.
module cpu_bus_ctrl
   import cpu_bus_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter logic [ADDR_W-1:0] MEM_LIMIT = 32'h0100_0000,
   parameter logic [15:0]       IO_BASE   = 16'hFF00,
   parameter int unsigned       IO_WAIT   = 2,
   parameter int unsigned       TIMEOUT   = 255
) (
   input  logic              i_cpu_clk,
   input  logic              i_rst,
   cpu_bus_if.slave          cpu,
   output logic              o_mem_cs,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   input  logic              i_mem_ack,
   output logic              o_io_sel,
   output logic              o_io_we,
   output logic [15:0]       o_io_addr,
   output logic [DATA_W-1:0] o_io_wdata,
   input  logic [DATA_W-1:0] i_io_rdata,
   output logic              o_bus_err,
   input  logic              i_err_clr
);

   localparam logic [15:0]       C_TIMEOUT = 16'(TIMEOUT);
   localparam logic [15:0]       C_IO_WAIT = 16'(IO_WAIT);
   localparam logic [DATA_W-1:0] C_FILL    = DATA_W'(BUS_FILL);

   state_e            r_state, w_state_next;
   logic              r_req_q;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [15:0]       r_cnt, w_cnt_next;
   logic [DATA_W-1:0] r_rdata, w_rdata_next;
   logic              r_bus_err;
   logic              w_req_edge;
   logic              w_accept;
   logic              w_set_err;
   target_e           w_target;

   cpu_bus_decode #(
      .ADDR_W    (ADDR_W),
      .MEM_LIMIT (MEM_LIMIT),
      .IO_BASE   (IO_BASE)
   ) u_decode (
      .i_addr   (cpu.i_addr),
      .o_target (w_target)
   );

   assign w_req_edge = cpu.i_req & ~r_req_q;

   // Next state, shared counter and read data. r_cnt is the timeout in MEM,
   // the remaining select cycles in IO, and a turnaround delay in RESP:
   // unmapped and I/O accesses spend one extra cycle in RESP before ready.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_rdata_next = r_rdata;
      w_accept     = 1'b0;
      w_set_err    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req_edge) begin
               w_accept = 1'b1;
               case (w_target)
                  T_MEM: begin
                     w_state_next = ST_MEM;
                     w_cnt_next   = C_TIMEOUT;
                  end
                  T_IO: begin
                     w_state_next = ST_IO;
                     w_cnt_next   = C_IO_WAIT;
                  end
                  default: begin
                     w_state_next = ST_RESP;
                     w_cnt_next   = 16'd1;
                     w_set_err    = 1'b1;
                     if (!cpu.i_we) w_rdata_next = C_FILL;
                  end
               endcase
            end
         end
         ST_MEM: begin
            if (i_mem_ack) begin
               // ack wins over a simultaneous expiry
               if (!r_we) w_rdata_next = i_mem_rdata;
               w_state_next = ST_RESP;
               w_cnt_next   = 16'd0;
            end else if (r_cnt == 16'd1) begin
               if (!r_we) w_rdata_next = C_FILL;
               w_set_err    = 1'b1;
               w_state_next = ST_RESP;
               w_cnt_next   = 16'd0;
            end else begin
               w_cnt_next = r_cnt - 16'd1;
            end
         end
         ST_IO: begin
            if (r_cnt == 16'd0) begin
               if (!r_we) w_rdata_next = i_io_rdata;
               w_state_next = ST_RESP;
               w_cnt_next   = 16'd1;
            end else begin
               w_cnt_next = r_cnt - 16'd1;
            end
         end
         default: begin
            if (r_cnt == 16'd0) begin
               w_state_next = ST_IDLE;
            end else begin
               w_cnt_next = r_cnt - 16'd1;
            end
         end
      endcase
   end

   // State, counter, captured request, read data and sticky error
   always_ff @(posedge i_cpu_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_req_q   <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_cnt     <= '0;
         r_rdata   <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_req_q <= cpu.i_req;
         r_cnt   <= w_cnt_next;
         r_rdata <= w_rdata_next;
         if (w_accept) begin
            r_we    <= cpu.i_we;
            r_addr  <= cpu.i_addr;
            r_wdata <= cpu.i_wdata;
         end
         if (w_set_err) begin
            r_bus_err <= 1'b1;
         end else if (i_err_clr) begin
            r_bus_err <= 1'b0;
         end
      end
   end

   assign o_mem_cs    = (r_state == ST_MEM);
   assign o_mem_we    = o_mem_cs & r_we;
   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = r_wdata;
   assign o_io_sel    = (r_state == ST_IO);
   assign o_io_we     = o_io_sel & r_we;
   assign o_io_addr   = r_addr[15:0];
   assign o_io_wdata  = r_wdata;
   assign o_bus_err   = r_bus_err;
   assign cpu.o_rdata = r_rdata;
   assign cpu.o_ready = (r_state == ST_RESP) && (r_cnt == 16'd0);

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Bench for cpu_bus_ctrl: a cycle-window transaction model checks every
// cycle, directed scenarios add literal expectations.
module tb_cpu_bus_ctrl;
   import cpu_bus_pkg::*;

   localparam int IO_WAIT = 2;
   localparam int TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_cs, mem_we, io_sel, io_we, bus_err;
   logic [31:0] mem_addr, mem_wdata, io_wdata;
   logic [15:0] io_addr;
   logic [31:0] mem_rdata = '0;
   logic [31:0] io_rdata  = '0;
   logic        mem_ack   = 1'b0;
   logic        err_clr   = 1'b0;

   always #5 clk = ~clk;

   cpu_bus_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   cpu_bus_ctrl #(
      .ADDR_W(32), .DATA_W(32), .MEM_LIMIT(32'h0100_0000), .IO_BASE(16'hFF00),
      .IO_WAIT(IO_WAIT), .TIMEOUT(TIMEOUT)
   ) dut (
      .i_cpu_clk(clk), .i_rst(rst), .cpu(bus),
      .o_mem_cs(mem_cs), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
      .o_io_sel(io_sel), .o_io_we(io_we), .o_io_addr(io_addr),
      .o_io_wdata(io_wdata), .i_io_rdata(io_rdata),
      .o_bus_err(bus_err), .i_err_clr(err_clr)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- model state (transaction windows in cycle numbers)
   int          cyc = 0;
   bit          m_active = 0;
   target_e     m_kind = T_NONE;
   int          m_n = 0;
   int          m_ready = -1;
   bit          m_we = 0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
   bit          m_err = 0;
   bit          m_prev_req = 0;
   // observed counters for literal checks
   int          cs_cnt = 0, sel_cnt = 0, n_ready = 0, last_ready = -1;

   // Per-cycle compare against the model, then advance the model
   always @(negedge clk) begin
      bit e_cs, e_sel, e_ready, edge_seen, set_err;
      if (rst) begin
         m_active = 0; m_err = 0; m_rdata = '0; m_prev_req = 0;
         check("rst_cs", mem_cs, 0);
         check("rst_sel", io_sel, 0);
         check("rst_ready", bus.o_ready, 0);
         check("rst_err", bus_err, 0);
         check("rst_rdata", bus.o_rdata, 0);
      end else begin
         e_cs    = m_active && m_kind == T_MEM && cyc > m_n && m_ready < 0;
         e_sel   = m_active && m_kind == T_IO && cyc > m_n && cyc <= m_n + IO_WAIT + 1;
         e_ready = m_active && cyc == m_ready;
         check("cs", mem_cs, e_cs);
         check("sel", io_sel, e_sel);
         check("ready", bus.o_ready, e_ready);
         check("err", bus_err, m_err);
         if (e_cs) begin
            check("mem_we", mem_we, m_we);
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
         end
         if (e_sel) begin
            check("io_we", io_we, m_we);
            check("io_addr", io_addr, m_addr[15:0]);
            check("io_wdata", io_wdata, m_wdata);
         end
         if (e_ready) check("rdata", bus.o_rdata, m_rdata);

         edge_seen  = bus.i_req && !m_prev_req;
         m_prev_req = bus.i_req;
         set_err    = 0;
         if (e_cs) begin
            if (mem_ack) begin
               m_ready = cyc + 1;
               if (!m_we) m_rdata = mem_rdata;
            end else if (cyc == m_n + TIMEOUT) begin
               m_ready = cyc + 1;
               if (!m_we) m_rdata = 32'hFFFF_FFFF;
               set_err = 1;
            end
         end
         if (e_sel && cyc == m_n + IO_WAIT + 1 && !m_we) m_rdata = io_rdata;
         if (edge_seen && !m_active) begin
            m_active = 1; m_n = cyc; m_we = bus.i_we;
            m_addr = bus.i_addr; m_wdata = bus.i_wdata;
            if (bus.i_addr[31:16] == 16'hFF00) begin
               m_kind = T_IO; m_ready = cyc + IO_WAIT + 3;
            end else if (bus.i_addr < 32'h0100_0000) begin
               m_kind = T_MEM; m_ready = -1;
            end else begin
               m_kind = T_NONE; m_ready = cyc + 2; set_err = 1;
               if (!bus.i_we) m_rdata = 32'hFFFF_FFFF;
            end
         end else if (e_ready) begin
            m_active = 0;
         end
         if (set_err) m_err = 1;
         else if (err_clr) m_err = 0;
      end
      if (mem_cs) cs_cnt++;
      if (io_sel) sel_cnt++;
      if (bus.o_ready) begin
         n_ready++;
         last_ready = cyc;
         $display("txn done cycle %0d rdata=%h err=%b", cyc, bus.o_rdata, bus_err);
      end
      cyc++;
   end

   // ---------------- driver helpers
   int edge_c, s_cs, s_sel, s_ready;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      bus.i_req = 1'b1; bus.i_we = we; bus.i_addr = addr; bus.i_wdata = wdata;
      edge_c = cyc; s_cs = cs_cnt; s_sel = sel_cnt; s_ready = n_ready;
   endtask

   task automatic wait_ready(input string name, input int budget);
      int k = 0;
      while (n_ready == s_ready && k < budget) begin
         tick();
         k++;
      end
      check({name, "_got_ready"}, (n_ready != s_ready), 1);
      bus.i_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_req = 0; bus.i_we = 0; bus.i_addr = '0; bus.i_wdata = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // memory read, ack on 4th cs cycle
      do_req(0, 32'h0000_1234, '0);
      repeat (4) tick();
      mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_ack = 0; mem_rdata = '0;
      wait_ready("mr", 20);
      check("mr_cs_cycles", cs_cnt - s_cs, 4);
      check("mr_latency", last_ready - edge_c, 5);
      check("mr_rdata", bus.o_rdata, 32'hDEAD_BEEF);
      check("mr_err", bus_err, 0);
      tick();

      // I/O write
      do_req(1, 32'hFF00_0010, 32'h0000_00A5);
      tick();
      check("iow_addr", io_addr, 16'h0010);
      check("iow_we", io_we, 1);
      check("iow_wdata", io_wdata, 32'h0000_00A5);
      wait_ready("iow", 20);
      check("iow_sel_cycles", sel_cnt - s_sel, 3);
      check("iow_latency", last_ready - edge_c, 5);
      check("iow_rdata_kept", bus.o_rdata, 32'hDEAD_BEEF);
      tick();

      // I/O read: data valid only on last select cycle
      do_req(0, 32'hFF00_0020, '0);
      io_rdata = 32'h1111_1111;
      repeat (3) tick();
      io_rdata = 32'hCAFE_0001;
      tick();
      io_rdata = 32'h2222_2222;
      wait_ready("ior", 20);
      check("ior_rdata", bus.o_rdata, 32'hCAFE_0001);
      tick();

      // memory timeout, then clear
      do_req(0, 32'h0000_0040, '0);
      wait_ready("to", 30);
      check("to_cs_cycles", cs_cnt - s_cs, 8);
      check("to_latency", last_ready - edge_c, 9);
      check("to_rdata", bus.o_rdata, 32'hFFFF_FFFF);
      check("to_err", bus_err, 1);
      err_clr = 1;
      tick();
      err_clr = 0;
      check("to_err_cleared", bus_err, 0);

      // unmapped read
      do_req(0, 32'h8000_0000, '0);
      wait_ready("um", 20);
      check("um_latency", last_ready - edge_c, 2);
      check("um_rdata", bus.o_rdata, 32'hFFFF_FFFF);
      check("um_err", bus_err, 1);
      err_clr = 1;
      tick();
      err_clr = 0;

      // second edge while memory is busy is ignored
      do_req(0, 32'h0000_0100, '0);
      tick();
      bus.i_req = 0;
      tick();
      bus.i_req = 1;
      repeat (2) tick();
      mem_ack = 1; mem_rdata = 32'h5555_AAAA;
      tick();
      mem_ack = 0;
      wait_ready("ign", 20);
      repeat (6) tick();
      check("ign_ready_count", n_ready - s_ready, 1);
      check("ign_cs_cycles", cs_cnt - s_cs, 4);
      check("ign_rdata", bus.o_rdata, 32'h5555_AAAA);

      // ack on the expiry cycle
      do_req(0, 32'h0000_0020, '0);
      repeat (8) tick();
      mem_ack = 1; mem_rdata = 32'h1234_5678;
      tick();
      mem_ack = 0;
      wait_ready("tie", 20);
      check("tie_latency", last_ready - edge_c, 9);
      check("tie_rdata", bus.o_rdata, 32'h1234_5678);
      check("tie_err", bus_err, 0);
      tick();

      // clear coincides with unmapped error
      do_req(0, 32'hF000_0000, '0);
      err_clr = 1;
      tick();
      err_clr = 0;
      wait_ready("sc", 20);
      check("sc_err", bus_err, 1);
      err_clr = 1;
      tick();
      err_clr = 0;

      // reset in the middle of a memory access
      do_req(0, 32'h0000_0080, '0);
      repeat (2) tick();
      rst = 1; bus.i_req = 0;
      #1;
      check("rst_mid_cs", mem_cs, 0);
      check("rst_mid_ready", bus.o_ready, 0);
      repeat (2) tick();
      rst = 0;
      tick();
      do_req(0, 32'h0000_0004, '0);
      tick();
      mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
      tick();
      mem_ack = 0;
      wait_ready("post", 20);
      check("post_latency", last_ready - edge_c, 2);
      check("post_rdata", bus.o_rdata, 32'h0BAD_F00D);
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
